// File: rtl/cracker_multi.sv
// Multi-lane key-search dispatcher: latches one ciphertext block, splits a key range
// into 2^CHUNK_LOG2-key jobs, farms them out to NUM_ENG engines and reports the first hit.
`timescale 1ns/1ps
module cracker_multi #(
  parameter int NUM_ENG    = 4,
  parameter int KEY_W      = 128,
  parameter int DATA_W     = 64,
  parameter int CHUNK_LOG2 = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [KEY_W-1:0]         base_key,
  input  logic [31:0]              num_jobs,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     data_valid,
  output logic                     busy,
  output logic                     rdy,
  output logic                     found,
  output logic [KEY_W-1:0]         result,
  output logic [31:0]              jobs_done,
  output logic [NUM_ENG-1:0]       eng_start,
  output logic [NUM_ENG-1:0]       eng_abort,
  output logic [NUM_ENG*KEY_W-1:0] eng_key_base,
  output logic [DATA_W-1:0]        eng_data,
  input  logic [NUM_ENG-1:0]       eng_rdy,
  input  logic [NUM_ENG-1:0]       eng_hit,
  input  logic [NUM_ENG*KEY_W-1:0] eng_key,
  output logic [1:0]               state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_DATA = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  state_t             state;
  logic [NUM_ENG-1:0] lane_busy;
  logic [31:0]        next_job;
  logic [31:0]        num_jobs_q;
  logic [KEY_W-1:0]   base_q;

  logic [NUM_ENG-1:0] done_v, hit_v, disp_oh;
  logic [KEY_W-1:0]   win_key, job_base;
  logic               any_hit, got_win, got_idle, jobs_left, disp_en;
  logic [31:0]        done_cnt;
  logic [32:0]        jobs_sum;

  // Lane handshake: eng_start is a one-cycle request that marks the lane busy; the lane
  // answers with a one-cycle eng_rdy (eng_hit/eng_key qualify it), honoured only while busy.
  always_comb begin
    done_v   = eng_rdy & lane_busy;
    hit_v    = done_v & eng_hit;
    any_hit  = |hit_v;
    got_win  = 1'b0;
    got_idle = 1'b0;
    win_key  = '0;
    disp_oh  = '0;
    done_cnt = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      if (hit_v[i] && !got_win) begin
        got_win = 1'b1;
        win_key = eng_key[i*KEY_W +: KEY_W];
      end
      if (!lane_busy[i] && !got_idle) begin
        got_idle   = 1'b1;
        disp_oh[i] = 1'b1;
      end
      done_cnt = done_cnt + {31'd0, done_v[i]};
    end
    jobs_left = next_job < num_jobs_q;
    disp_en   = (state == RUN) && !any_hit && jobs_left && got_idle;
    job_base  = base_q + (KEY_W'(next_job) << CHUNK_LOG2);
    jobs_sum  = {1'b0, jobs_done} + {1'b0, done_cnt};
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      lane_busy    <= '0;
      next_job     <= '0;
      num_jobs_q   <= '0;
      base_q       <= '0;
      busy         <= 1'b0;
      rdy          <= 1'b0;
      found        <= 1'b0;
      result       <= '0;
      jobs_done    <= '0;
      eng_start    <= '0;
      eng_abort    <= '0;
      eng_key_base <= '0;
      eng_data     <= '0;
    end else begin
      eng_start <= '0;
      eng_abort <= '0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            base_q     <= base_key;
            num_jobs_q <= num_jobs;
            next_job   <= '0;
            rdy        <= 1'b0;
            found      <= 1'b0;
            result     <= '0;
            jobs_done  <= '0;
            busy       <= 1'b1;
            state      <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (data_valid) begin
            eng_data <= data_in;
            if (num_jobs_q == '0) begin
              busy  <= 1'b0;
              rdy   <= 1'b1;
              state <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          jobs_done <= jobs_sum[32] ? '1 : jobs_sum[31:0];
          if (any_hit) begin
            // Lanes reporting this cycle are already finished, so only the others are aborted.
            result    <= win_key;
            found     <= 1'b1;
            rdy       <= 1'b1;
            busy      <= 1'b0;
            eng_abort <= lane_busy & ~done_v;
            lane_busy <= '0;
            state     <= DONE;
          end else if (!jobs_left && lane_busy == '0) begin
            rdy   <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            lane_busy <= (lane_busy & ~done_v) | (disp_en ? disp_oh : '0);
            if (disp_en) begin
              eng_start <= disp_oh;
              next_job  <= next_job + 32'd1;
              for (int i = 0; i < NUM_ENG; i++) begin
                if (disp_oh[i]) eng_key_base[i*KEY_W +: KEY_W] <= job_base;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cracker_multi.sv
// Bench for cracker_multi: a table of whole runs answered by a latency-based lane model,
// plus directed sequences for dispatch timing, hit priority, wrap and reset corners.
`timescale 1ns/1ps
module tb_cracker_multi;

  localparam int NE = 4;
  localparam int KW = 128;
  localparam logic [31:0] NO_HIT = 32'hFFFF_FFFF;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [KW-1:0]   base_key;
  logic [31:0]     num_jobs;
  logic [63:0]     data_in;
  logic            data_valid;
  logic            busy, rdy, found;
  logic [KW-1:0]   result;
  logic [31:0]     jobs_done;
  logic [NE-1:0]   eng_start, eng_abort, eng_rdy, eng_hit;
  logic [NE*KW-1:0] eng_key_base, eng_key;
  logic [63:0]     eng_data;
  logic [1:0]      state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // lane model state
  bit          act[NE];
  int          cnt[NE];
  logic [31:0] job[NE];

  typedef struct {
    logic [KW-1:0] base;
    logic [31:0]   n;
    int            lat;
    logic [31:0]   hit_job;
    logic [KW-1:0] hit_key;
    logic          exp_found;
    logic [KW-1:0] exp_result;
    logic [31:0]   exp_jobs;
    int            exp_starts;
  } vec_t;

  vec_t vecs[5];

  cracker_multi #(.NUM_ENG(NE), .KEY_W(KW), .DATA_W(64), .CHUNK_LOG2(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_key(base_key), .num_jobs(num_jobs),
    .data_in(data_in), .data_valid(data_valid), .busy(busy), .rdy(rdy), .found(found),
    .result(result), .jobs_done(jobs_done), .eng_start(eng_start), .eng_abort(eng_abort),
    .eng_key_base(eng_key_base), .eng_data(eng_data), .eng_rdy(eng_rdy), .eng_hit(eng_hit),
    .eng_key(eng_key), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [KW-1:0] got, input logic [KW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic begin_run(input logic [KW-1:0] b, input logic [31:0] n, input logic [63:0] d);
    base_key = b;
    num_jobs = n;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    data_in = d;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic wait_start(input int lane, input logic [KW-1:0] exp_base, input string name);
    int k;
    logic [NE-1:0] m;
    k = 0;
    m = 4'b0001 << lane;
    do begin
      tick();
      k++;
    end while (eng_start == '0 && k < 20);
    check({name, " start"}, eng_start, m);
    check({name, " base"}, eng_key_base[lane*KW +: KW], exp_base);
  endtask

  task automatic wait_rdy(input string name);
    int k;
    k = 0;
    while (!rdy && k < 50) begin
      tick();
      k++;
    end
    check({name, " rdy"}, rdy, 1);
  endtask

  task automatic respond(input logic [KW-1:0] b, input logic [31:0] hj,
                         input logic [KW-1:0] hk, input int lat);
    logic [KW-1:0] d;
    eng_rdy = '0;
    eng_hit = '0;
    for (int i = 0; i < NE; i++) begin
      if (eng_abort[i]) act[i] = 1'b0;
      if (eng_start[i]) begin
        act[i] = 1'b1;
        cnt[i] = lat;
        d = eng_key_base[i*KW +: KW] - b;
        job[i] = d[47:16];
      end else if (act[i]) begin
        if (cnt[i] == 0) begin
          act[i] = 1'b0;
          eng_rdy[i] = 1'b1;
          if (job[i] == hj) begin
            eng_hit[i] = 1'b1;
            eng_key[i*KW +: KW] = hk;
          end
        end else begin
          cnt[i]--;
        end
      end
    end
  endtask

  task automatic run_case(input int k);
    vec_t v;
    int starts, c;
    v = vecs[k];
    for (int i = 0; i < NE; i++) act[i] = 1'b0;
    base_key = v.base;
    num_jobs = v.n;
    start = 1'b1;
    tick();
    start = 1'b0;
    check($sformatf("case%0d busy", k), busy, 1);
    check($sformatf("case%0d rdy cleared", k), rdy, 0);
    tick();
    data_in = 64'hC0DE_0000_0000_0000 | 64'(k);
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    check($sformatf("case%0d eng_data", k), eng_data, 64'hC0DE_0000_0000_0000 | 64'(k));
    starts = 0;
    c = 0;
    while (!rdy && c < 300) begin
      tick();
      starts += $countones(eng_start);
      respond(v.base, v.hit_job, v.hit_key, v.lat);
      c++;
    end
    eng_rdy = '0;
    eng_hit = '0;
    check($sformatf("case%0d rdy", k), rdy, 1);
    check($sformatf("case%0d busy", k), busy, 0);
    check($sformatf("case%0d found", k), found, v.exp_found);
    check($sformatf("case%0d result", k), result, v.exp_result);
    check($sformatf("case%0d jobs_done", k), jobs_done, v.exp_jobs);
    check($sformatf("case%0d starts", k), starts, v.exp_starts);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [KW-1:0] wb;
    logic [NE-1:0] seen;

    vecs[0] = '{128'h1000,     32'd6,  3,  NO_HIT, 128'h0,      1'b0, 128'h0,      32'd6, 6};
    vecs[1] = '{128'h0,        32'd1,  0,  NO_HIT, 128'h0,      1'b0, 128'h0,      32'd1, 1};
    vecs[2] = '{128'h5_0000,   32'd8,  10, 32'd0,  128'hCAFE,   1'b1, 128'hCAFE,   32'd1, 4};
    vecs[3] = '{128'h7_0000_0000, 32'd10, 10, 32'd2, 128'hBEEF, 1'b1, 128'hBEEF,   32'd3, 5};
    vecs[4] = '{'1,            32'd3,  1,  NO_HIT, 128'h0,      1'b0, 128'h0,      32'd3, 3};

    rst = 1'b0;
    start = 1'b0;
    base_key = '0;
    num_jobs = '0;
    data_in = '0;
    data_valid = 1'b0;
    eng_rdy = '0;
    eng_hit = '0;
    for (int i = 0; i < NE; i++) eng_key[i*KW +: KW] = 128'hF00D_0000 + 128'(i);

    // reset state
    tick();
    tick();
    check("reset busy", busy, 0);
    check("reset rdy", rdy, 0);
    check("reset found", found, 0);
    check("reset result", result, 0);
    check("reset jobs_done", jobs_done, 0);
    check("reset eng_start", eng_start, 0);
    check("reset eng_abort", eng_abort, 0);
    check("reset eng_data", eng_data, 0);
    check("reset state", state_dbg, 0);
    rst = 1'b1;
    tick();

    // A: four jobs, one dispatch per cycle starting one cycle after data acceptance
    base_key = '0;
    num_jobs = 32'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    data_in = 64'h0123_4567_89AB_CDEF;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    check("A no start at accept", eng_start, 0);
    check("A eng_data", eng_data, 64'h0123_4567_89AB_CDEF);
    for (int i = 0; i < NE; i++) begin
      logic [NE-1:0] m;
      m = 4'b0001 << i;
      tick();
      check($sformatf("A start %0d", i), eng_start, m);
      check($sformatf("A base %0d", i), eng_key_base[i*KW +: KW], 128'(i) << 16);
    end
    tick();
    check("A no fifth start", eng_start, 0);
    eng_rdy = 4'hF;
    tick();
    eng_rdy = '0;
    wait_rdy("A");
    check("A found", found, 0);
    check("A result", result, 0);
    check("A jobs_done", jobs_done, 4);
    check("A busy", busy, 0);
    check("A state", state_dbg, 3);
    check("A base held", eng_key_base[3*KW +: KW], 128'h30000);

    // B: lane 2 hits on its third job
    begin_run('0, 32'd10, 64'h1111);
    wait_start(0, 128'h00000, "B0");
    wait_start(1, 128'h10000, "B1");
    wait_start(2, 128'h20000, "B2");
    wait_start(3, 128'h30000, "B3");
    eng_rdy = 4'b0100;
    tick();
    eng_rdy = '0;
    wait_start(2, 128'h40000, "B2b");
    eng_rdy = 4'b0100;
    tick();
    eng_rdy = '0;
    wait_start(2, 128'h50000, "B2c");
    eng_rdy = 4'b0100;
    eng_hit = 4'b0100;
    eng_key[2*KW +: KW] = 128'h1234_5678;
    tick();
    eng_rdy = '0;
    eng_hit = '0;
    check("B abort", eng_abort, 4'b1011);
    check("B result", result, 128'h1234_5678);
    check("B found", found, 1);
    check("B rdy", rdy, 1);
    check("B busy", busy, 0);
    check("B jobs_done", jobs_done, 3);
    check("B no start on hit", eng_start, 0);
    seen = '0;
    repeat (4) begin
      tick();
      seen |= eng_start | eng_abort;
    end
    check("B quiet after hit", seen, 0);
    check("B result held", result, 128'h1234_5678);

    // C: lanes 1 and 3 hit together while lane 0 is idle and jobs remain
    begin_run(128'h100, 32'd10, 64'h2222);
    wait_start(0, 128'h00100, "C0");
    wait_start(1, 128'h10100, "C1");
    wait_start(2, 128'h20100, "C2");
    wait_start(3, 128'h30100, "C3");
    eng_rdy = 4'b0001;
    tick();
    eng_rdy = 4'b1010;
    eng_hit = 4'b1010;
    eng_key[1*KW +: KW] = 128'hAA;
    eng_key[3*KW +: KW] = 128'hBB;
    tick();
    eng_rdy = '0;
    eng_hit = '0;
    check("C no start on hit", eng_start, 0);
    check("C result", result, 128'hAA);
    check("C found", found, 1);
    check("C abort", eng_abort, 4'b0100);
    check("C jobs_done", jobs_done, 3);

    // D: empty range
    begin_run(128'h55, 32'd0, 64'h3333);
    check("D rdy", rdy, 1);
    check("D found", found, 0);
    check("D busy", busy, 0);
    seen = '0;
    repeat (5) begin
      tick();
      seen |= eng_start;
    end
    check("D no start", seen, 0);
    check("D jobs_done", jobs_done, 0);

    // E: key base wraps; a report from an idle lane is ignored
    wb = '0 - 128'h8000;
    begin_run(wb, 32'd2, 64'h4444);
    wait_start(0, wb, "E0");
    wait_start(1, 128'h8000, "E1");
    eng_rdy = 4'b1000;
    eng_hit = 4'b1000;
    eng_key[3*KW +: KW] = 128'h999;
    tick();
    eng_hit = '0;
    eng_rdy = 4'b0011;
    tick();
    eng_rdy = '0;
    wait_rdy("E");
    check("E found", found, 0);
    check("E result", result, 0);
    check("E jobs_done", jobs_done, 2);

    // F: asynchronous reset with three lanes busy, then a clean run ignoring extra starts
    begin_run('0, 32'd10, 64'h5555);
    wait_start(0, 128'h00000, "F0");
    wait_start(1, 128'h10000, "F1");
    wait_start(2, 128'h20000, "F2");
    #2;
    rst = 1'b0;
    #1;
    check("F rst busy", busy, 0);
    check("F rst eng_start", eng_start, 0);
    check("F rst eng_abort", eng_abort, 0);
    check("F rst eng_key_base", eng_key_base[2*KW +: KW], 0);
    check("F rst eng_data", eng_data, 0);
    check("F rst state", state_dbg, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    base_key = 128'h10_0000;
    num_jobs = 32'd1;
    start = 1'b1;
    tick();
    base_key = 128'hDEAD_0000;
    num_jobs = 32'd5;
    tick();
    start = 1'b0;
    check("F busy", busy, 1);
    data_in = 64'h6666;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    wait_start(0, 128'h10_0000, "F new");
    start = 1'b1;
    eng_rdy = 4'b0001;
    tick();
    start = 1'b0;
    eng_rdy = '0;
    wait_rdy("F");
    check("F jobs_done", jobs_done, 1);
    check("F found", found, 0);

    // table of whole runs
    for (int k = 0; k < 5; k++) run_case(k);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cracker_multi.md
Name: cracker_multi

Overview:
Parametrised successor to the single-engine cracker top. Captures one ciphertext block from the file reader and partitions a key range into fixed-size jobs. Dispatches jobs across NUM_ENG external search engines (kombajn-class) and returns the first cracked key with found/rdy status. First hit aborts all other engines. Exhausting the range without a hit reports not-found.

Parameters:
NUM_ENG, 4, number of engine lanes (1..16)
KEY_W, 128, key width
DATA_W, 64, ciphertext block width
CHUNK_LOG2, 16, log2 of keys per job

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a run
base_key  input  KEY_W  first key of range, sampled on accepted start
num_jobs  input  32  number of jobs, sampled on accepted start
data_in  input  DATA_W  ciphertext block from reader
data_valid  input  1  data_in valid (reader done)
busy  output  1  run in progress
rdy  output  1  run finished (level)
found  output  1  key found in finished run
result  output  KEY_W  cracked key
jobs_done  output  32  completed job count of current/last run
eng_start  output  NUM_ENG  one-cycle job start per lane
eng_abort  output  NUM_ENG  one-cycle abort per lane
eng_key_base  output  NUM_ENG*KEY_W  job base key per lane, lane i at [i*KEY_W +: KEY_W]
eng_data  output  DATA_W  latched ciphertext, shared
eng_rdy  input  NUM_ENG  lane finished its job (pulse)
eng_hit  input  NUM_ENG  qualifies eng_rdy: key found
eng_key  input  NUM_ENG*KEY_W  lane's found key, valid with eng_rdy&eng_hit

Behaviour:
- Reset (rst=0, async): state IDLE.
  - All outputs 0.
  - Internal lane-busy bits 0.
  - next_job 0.
- States: IDLE, WAIT_DATA, RUN, DONE.
- IDLE/DONE:
  - start=1 samples base_key and num_jobs.
  - Clears rdy, found, result, jobs_done.
  - Sets busy and moves to WAIT_DATA.
  - start while busy=1 is ignored.
- WAIT_DATA:
  - On data_valid=1, latch data_in into eng_data and go to RUN.
  - If num_jobs==0, go directly to DONE with found=0. rdy rises the cycle after data_valid.
- RUN, dispatch:
  - At most one eng_start per cycle, to the lowest-index idle lane, while next_job < num_jobs.
  - eng_key_base[lane] = base_key + (next_job << CHUNK_LOG2), modulo 2^KEY_W (wrap allowed, no error).
  - eng_key_base is held stable until the lane's next dispatch.
  - Lane becomes busy in the cycle of eng_start.
  - First eng_start occurs exactly 1 cycle after data_valid is accepted.
- RUN, completion:
  - eng_rdy[i] is honoured only when lane i is busy; otherwise ignored.
  - Honoured eng_rdy frees the lane from the next cycle; no same-cycle redispatch to that lane.
  - jobs_done += popcount of honoured eng_rdy, saturating at 2^32-1.
- RUN, hit:
  - Any honoured eng_rdy&eng_hit: lowest-index hitting lane wins.
  - result <= its eng_key.
  - eng_abort pulses for 1 cycle on every other lane still busy.
  - All busy bits clear, no further dispatch, go to DONE.
  - found=1 and rdy=1 from the next cycle.
- RUN, exhaust: next_job==num_jobs and no lane busy and no hit → DONE, found=0, result=0.
- DONE:
  - rdy=1 and busy=0 held until the next accepted start.
  - result/found remain stable.
- Hit coincides with last completion: hit takes priority, found=1.
- Dispatch coincides with a hit in the same cycle: no eng_start is issued that cycle.
- Reset mid-run: immediate return to IDLE, outputs 0. No eng_abort is issued; engines share rst.

Test Plan:
- NUM_ENG=4, CHUNK_LOG2=16, base_key=0, num_jobs=4, data_valid at cycle 5, no hits → eng_start to lanes 0,1,2,3 on cycles 6..9. Bases are 0, 0x10000, 0x20000, 0x30000. All eng_rdy → rdy=1, found=0, jobs_done=4.
- num_jobs=10, lane 2 returns eng_hit with eng_key=0x1234_5678 on its 3rd job → result=0x1234_5678, found=1, eng_abort on all other busy lanes for 1 cycle, no further eng_start.
- Lanes 1 and 3 hit in the same cycle with keys 0xAA and 0xBB → result=0xAA.
- num_jobs=0 → rdy=1, found=0 one cycle after data_valid; eng_start never asserted.
- base_key=2^128-0x8000, num_jobs=2 → job 1 base wraps to 0x8000.
- Assert rst=0 mid-RUN with 3 lanes busy → all outputs 0 asynchronously. A new start after release runs normally; start pulses during busy are ignored.
